bcd_stream_to_bin: RTL
======================

Name: bcd_stream_to_bin

Overview:
- Downstream consumer of the BCD checker stage. Accepts a stream of 4-bit decimal digits, most significant digit first, each paired with the checker's validity flag.
- Accumulates each number into binary using a sequential multiply-by-10-and-add, one digit per cycle.
- Presents the result on a valid/ready output handshake, with an error indication for non-BCD digits or overlong numbers.
- Sits between the digit source and the arithmetic/display datapath.

Parameters:
- DIGITS, 4, maximum digits per number.
- BIN_W, 14, binary result width. Must satisfy 10^DIGITS - 1 < 2^BIN_W.
- CNT_W, 3, width of the digit counter. Must satisfy 2^CNT_W > DIGITS.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- digit_in  in  4  current digit.
- bcd_flag  in  1  checker output; 1 = digit_in is a legal BCD digit (0-9).
- digit_valid  in  1  digit_in/bcd_flag/last are valid this cycle.
- last  in  1  current digit is the final digit of the number.
- digit_ready  out  1  block accepts a digit this cycle.
- bin_out  out  BIN_W  converted binary value.
- bin_valid  out  1  bin_out/err are valid.
- bin_ready  in  1  consumer accepts the result.
- err  out  1  result is invalid (bad digit or too many digits).
- digit_count  out  CNT_W  digits accepted for the current number.

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high.
- Reset values: state=COLLECT, acc=0, bin_out=0, bin_valid=0, err=0, digit_count=0. digit_ready=0 while rst=1, and 1 on the first cycle after rst drops.
- Reset mid-operation: discards any partial number or pending result, with no output.
- Digit transfer: occurs on a cycle with digit_valid & digit_ready.
- Result transfer: occurs on a cycle with bin_valid & bin_ready.
- States and outputs:
  - COLLECT: digit_ready=1, bin_valid=0.
  - FLUSH: digit_ready=1, bin_valid=0.
  - DONE: digit_ready=0, bin_valid=1.
- COLLECT, on a transfer:
  - Digit valid: acc <= (acc<<3) + (acc<<1) + digit_in, computed at BIN_W+4 bits and truncated to BIN_W (no truncation occurs within the legal range). digit_count increments.
  - Digit invalid (bcd_flag=0): err_sticky <= 1 and acc is not updated. If last=1, go to DONE; otherwise go to FLUSH.
  - Valid digit with last=1: go to DONE.
  - Valid digit with last=0 and new digit_count == DIGITS: err_sticky <= 1, go to FLUSH.
- FLUSH: consumes and discards digits until a transfer with last=1, then goes to DONE.
- Entering DONE:
  - No error: bin_out <= updated acc.
  - With error: bin_out <= 0.
  - err <= err_sticky.
- Latency: bin_valid rises in the cycle after the last-digit transfer.
- DONE:
  - bin_out and err are held stable until the result transfer.
  - On the result transfer: next cycle is COLLECT with acc=0, digit_count=0, err=0, err_sticky=0, bin_valid=0.
  - No digit is accepted in the same cycle as the result transfer.
- Edge cases:
  - digit_valid=0: no state change.
  - Inputs are ignored while digit_ready=0.
  - last=1 on the first digit is legal (single-digit number).
  - Leading zeros are legal and counted toward DIGITS.

Optional Feature:
- Macro: BCD_LOCAL_CHECK_EN.
- Defined: a digit is invalid if bcd_flag=0 OR digit_in > 4'd9, i.e. a redundant local range check that guards against a faulty or absent upstream checker.
- Undefined: validity is taken solely from bcd_flag. The port list is identical in both builds.

Test Plan:
1. Digits 1,2,3,4 (last on 4), bin_ready=1 -> bin_valid one cycle after the 4th transfer; bin_out=1234 (0x4D2), err=0, digit_count=4.
2. Single digit 7 with last=1 -> bin_out=7, err=0. Then 9,9,9,9 -> bin_out=9999 (0x270F), err=0.
3. Digits 1, 0xA with bcd_flag=0, 3 with last -> err=1, bin_out=0. Next number 5 with last -> bin_out=5, err=0.
4. Digits 1,2,3,4 with no last, then 5, then 6 with last -> FLUSH consumes 5 and 6; result err=1, bin_out=0.
5. Backpressure: after 4,2 with last, hold bin_ready=0 for 3 cycles -> bin_valid=1, bin_out=42 stable, digit_ready=0 throughout; bin_ready=1 -> digit_ready=1 on the next cycle.
6. Reset mid-collect: digits 3,6, then rst for 1 cycle, then 8 with last -> bin_out=8, err=0. With BCD_LOCAL_CHECK_EN: digit 0xC with bcd_flag=1 and last -> err=1.

Source files
------------

// File: rtl/bcd_stream_to_bin.sv
// Converts an MSD-first stream of BCD digits into a binary value with a valid/ready result port.
// Define BCD_LOCAL_CHECK_EN to also reject digits above 9 locally, independent of bcd_flag.
module bcd_stream_to_bin #(
    parameter int unsigned DIGITS = 4,
    parameter int unsigned BIN_W  = 14,
    parameter int unsigned CNT_W  = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       digit_in,
    input  logic             bcd_flag,
    input  logic             digit_valid,
    input  logic             last,
    output logic             digit_ready,
    output logic [BIN_W-1:0] bin_out,
    output logic             bin_valid,
    input  logic             bin_ready,
    output logic             err,
    output logic [CNT_W-1:0] digit_count
);

    typedef enum logic [1:0] {StCollect, StFlush, StDone} state_e;

    state_e           r_state;
    logic [BIN_W-1:0] r_acc;
    logic [BIN_W-1:0] r_bin_out;
    logic             r_bin_valid;
    logic             r_err;
    logic             r_err_sticky;
    logic [CNT_W-1:0] r_digit_count;
    logic             r_digit_ready;

    logic             w_digit_ok;
    logic [BIN_W+3:0] w_acc_wide;
    logic [BIN_W-1:0] w_acc_next;
    logic [CNT_W-1:0] w_cnt_next;

`ifdef BCD_LOCAL_CHECK_EN
    assign w_digit_ok = bcd_flag & (digit_in <= 4'd9);
`else
    assign w_digit_ok = bcd_flag;
`endif

    // acc*10 + digit as shift-and-add, widened so intermediate sums never wrap
    assign w_acc_wide = ({4'b0000, r_acc} << 3) + ({4'b0000, r_acc} << 1)
                      + {{BIN_W{1'b0}}, digit_in};
    assign w_acc_next = w_acc_wide[BIN_W-1:0];
    assign w_cnt_next = r_digit_count + CNT_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= StCollect;
            r_acc         <= '0;
            r_bin_out     <= '0;
            r_bin_valid   <= 1'b0;
            r_err         <= 1'b0;
            r_err_sticky  <= 1'b0;
            r_digit_count <= '0;
            r_digit_ready <= 1'b1;
        end else begin
            case (r_state)
                StCollect: begin
                    if (digit_valid) begin
                        if (!w_digit_ok) begin
                            r_err_sticky <= 1'b1;
                            if (last) begin
                                r_state       <= StDone;
                                r_bin_out     <= '0;
                                r_err         <= 1'b1;
                                r_bin_valid   <= 1'b1;
                                r_digit_ready <= 1'b0;
                            end else begin
                                r_state <= StFlush;
                            end
                        end else begin
                            r_acc         <= w_acc_next;
                            r_digit_count <= w_cnt_next;
                            if (last) begin
                                r_state       <= StDone;
                                r_bin_out     <= r_err_sticky ? '0 : w_acc_next;
                                r_err         <= r_err_sticky;
                                r_bin_valid   <= 1'b1;
                                r_digit_ready <= 1'b0;
                            end else if (w_cnt_next == CNT_W'(DIGITS)) begin
                                // Digit budget used up without last: number is overlong
                                r_err_sticky <= 1'b1;
                                r_state      <= StFlush;
                            end
                        end
                    end
                end
                StFlush: begin
                    if (digit_valid && last) begin
                        r_state       <= StDone;
                        r_bin_out     <= r_err_sticky ? '0 : r_acc;
                        r_err         <= r_err_sticky;
                        r_bin_valid   <= 1'b1;
                        r_digit_ready <= 1'b0;
                    end
                end
                StDone: begin
                    if (bin_ready) begin
                        r_state       <= StCollect;
                        r_acc         <= '0;
                        r_digit_count <= '0;
                        r_err         <= 1'b0;
                        r_err_sticky  <= 1'b0;
                        r_bin_valid   <= 1'b0;
                        r_digit_ready <= 1'b1;
                    end
                end
                default: begin
                    r_state <= StCollect;
                end
            endcase
        end
    end

    assign digit_ready = r_digit_ready & ~rst;
    assign bin_out     = r_bin_out;
    assign bin_valid   = r_bin_valid;
    assign err         = r_err;
    assign digit_count = r_digit_count;

endmodule
